// File: rtl/stack_op_sequencer.sv
// Multicycle controller that runs one stack-machine operation per request
// against an external registered-output LIFO. It sequences the push/pop/tos
// strobes, captures read data, performs the ALU step and keeps a depth count
// that is used to reject overflowing and underflowing requests.
//
// Handshake: start is a request strobe that is only looked at in IDLE; op
// and imm are latched in that same cycle. busy is high in every non-IDLE
// state. done is a single-cycle pulse in DONE, and err is meaningful while
// done is high. The stack's st_dout is valid the cycle after st_pop/st_tos.
module stack_op_sequencer #(
  parameter int DEPTH = 32,
  parameter int W     = 8,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [W-1:0]  imm,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic [DW-1:0] depth,
  output logic [W-1:0]  st_din,
  output logic          st_push,
  output logic          st_pop,
  output logic          st_tos,
  input  logic [W-1:0]  st_dout
);

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_POP  = 3'd1,
    OP_PEEK = 3'd2,
    OP_DUP  = 3'd3,
    OP_SWAP = 3'd4,
    OP_ADD  = 3'd5,
    OP_SUB  = 3'd6,
    OP_AND  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP_A = 3'd1,
    POP_B = 3'd2,
    CAP_B = 3'd3,
    WR_1  = 3'd4,
    WR_2  = 3'd5,
    DONE  = 3'd6
  } state_e;

  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [W-1:0]  imm_q, imm_d;
  logic          err_q, err_d;
  logic [W-1:0]  result_q, result_d;
  logic [DW-1:0] depth_q, depth_d;
  logic [W-1:0]  opa_q, opa_d;
  logic [W-1:0]  opb_q, opb_d;

  logic          is_alu;
  logic          illegal;
  logic [W-1:0]  alu_r;
  op_e           op_in;

  assign op_in  = op_e'(op);
  assign is_alu = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_AND);

  // ALU result; opa is the old top, opb the entry beneath it.
  always_comb begin
    alu_r = opb_q & opa_q;
    case (op_q)
      OP_ADD:  alu_r = opb_q + opa_q;
      OP_SUB:  alu_r = opb_q - opa_q;
      default: alu_r = opb_q & opa_q;
    endcase
  end

  // Legality of the incoming request against the current depth.
  always_comb begin
    illegal = 1'b0;
    case (op_in)
      OP_PUSH:                 illegal = (depth_q == DEPTH_MAX);
      OP_DUP:                  illegal = (depth_q == DEPTH_MAX) || (depth_q == '0);
      OP_POP, OP_PEEK:         illegal = (depth_q == '0);
      default:                 illegal = (depth_q < DW'(2));
    endcase
  end

  // Next-state, strobe decode and datapath capture.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    imm_d    = imm_q;
    err_d    = err_q;
    result_d = result_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    st_push  = 1'b0;
    st_pop   = 1'b0;
    st_tos   = 1'b0;
    st_din   = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = op_in;
          imm_d = imm;
          err_d = illegal;
          if (illegal)              state_d = DONE;
          else if (op_in == OP_PUSH) state_d = WR_1;
          else                      state_d = POP_A;
        end
      end
      POP_A: begin
        // PEEK and DUP only read the top; everything else consumes it.
        if ((op_q == OP_PEEK) || (op_q == OP_DUP)) st_tos = 1'b1;
        else                                       st_pop = 1'b1;
        state_d = POP_B;
      end
      POP_B: begin
        case (op_q)
          OP_POP, OP_PEEK: begin
            result_d = st_dout;
            state_d  = DONE;
          end
          OP_DUP: begin
            opa_d    = st_dout;
            result_d = st_dout;
            state_d  = WR_1;
          end
          default: begin
            opa_d   = st_dout;
            st_pop  = 1'b1;
            state_d = CAP_B;
          end
        endcase
      end
      CAP_B: begin
        opb_d   = st_dout;
        state_d = WR_1;
      end
      WR_1: begin
        st_push = 1'b1;
        state_d = DONE;
        if (op_q == OP_PUSH) begin
          st_din = imm_q;
        end else if (is_alu) begin
          st_din   = alu_r;
          result_d = alu_r;
        end else begin
          st_din = opa_q;
          if (op_q == OP_SWAP) state_d = WR_2;
        end
      end
      WR_2: begin
        // Pushing the old second last leaves it on top.
        st_push = 1'b1;
        st_din  = opb_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Depth tracks the strobes actually issued; guarded against wrap.
  always_comb begin
    depth_d = depth_q;
    if (st_push && (depth_q != DEPTH_MAX))  depth_d = depth_q + DW'(1);
    else if (st_pop && (depth_q != '0))     depth_d = depth_q - DW'(1);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= OP_PUSH;
      imm_q    <= '0;
      err_q    <= 1'b0;
      result_q <= '0;
      depth_q  <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      imm_q    <= imm_d;
      err_q    <= err_d;
      result_q <= result_d;
      depth_q  <= depth_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign err    = err_q & done;
  assign result = result_q;
  assign depth  = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Bench for stack_op_sequencer: a behavioural LIFO answers the strobes, and a
// queue-based reference model predicts result, depth, err and latency.
module tb_stack_op_sequencer;

  localparam int DEPTH = 32;
  localparam int W     = 8;
  localparam int DW    = $clog2(DEPTH + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [2:0]    op_i  = 3'd0;
  logic [W-1:0]  imm_i = '0;
  logic          busy, done, err;
  logic [W-1:0]  result;
  logic [DW-1:0] depth;
  logic [W-1:0]  st_din;
  logic          st_push, st_pop, st_tos;
  logic [W-1:0]  st_dout;

  stack_op_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op_i), .imm(imm_i),
    .busy(busy), .done(done), .err(err), .result(result), .depth(depth),
    .st_din(st_din), .st_push(st_push), .st_pop(st_pop), .st_tos(st_tos),
    .st_dout(st_dout)
  );

  // ---------------- stack datapath model ----------------
  logic [W-1:0] smem [0:DEPTH-1];
  int           sp;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp      <= 0;
      st_dout <= '0;
    end else if (st_push) begin
      if (sp < DEPTH) begin
        smem[sp] <= st_din;
        sp       <= sp + 1;
      end
    end else if (st_pop) begin
      if (sp > 0) begin
        st_dout <= smem[sp-1];
        sp      <= sp - 1;
      end
    end else if (st_tos) begin
      if (sp > 0) st_dout <= smem[sp-1];
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];          // reference stack contents, top at the end
  logic [W-1:0] m_result = '0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a negedge while the DUT is idle; returns at a negedge in IDLE.
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] v, input bit noisy);
    int           n;
    int           e_lat;
    bit           e_err;
    logic [W-1:0] a, b, r;
    int           lat;
    bit           got, saw;
    n     = exp_q.size();
    e_err = ((o == 3'd0 || o == 3'd3) && n == DEPTH) ||
            ((o == 3'd1 || o == 3'd2 || o == 3'd3) && n < 1) ||
            (o >= 3'd4 && n < 2);
    e_lat = 1;
    if (!e_err) begin
      case (o)
        3'd0: begin exp_q.push_back(v); e_lat = 2; end
        3'd1: begin m_result = exp_q.pop_back(); e_lat = 3; end
        3'd2: begin m_result = exp_q[n-1]; e_lat = 3; end
        3'd3: begin m_result = exp_q[n-1]; exp_q.push_back(exp_q[n-1]); e_lat = 4; end
        3'd4: begin
          a = exp_q.pop_back(); b = exp_q.pop_back();
          exp_q.push_back(a); exp_q.push_back(b); e_lat = 6;
        end
        default: begin
          a = exp_q.pop_back(); b = exp_q.pop_back();
          r = (o == 3'd5) ? b + a : (o == 3'd6) ? b - a : b & a;
          exp_q.push_back(r); m_result = r; e_lat = 5;
        end
      endcase
    end
    start = 1'b1; op_i = o; imm_i = v;
    lat = 0; got = 1'b0; saw = 1'b0;
    while (!got && lat < 10) begin
      @(posedge clk); @(negedge clk);
      lat++;
      start = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      op_i  = 3'($urandom_range(0, 7));
      imm_i = W'($urandom);
      chk("strobe_onehot", 32'($countones({st_push, st_pop, st_tos}) <= 1), 32'd1);
      if (!st_push) chk("st_din_zero", 32'(st_din), 32'd0);
      if (st_push || st_pop || st_tos) saw = 1'b1;
      chk("busy_high", 32'(busy), 32'd1);
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(e_lat));
    chk("err", 32'(err), 32'(e_err));
    chk("result", 32'(result), 32'(m_result));
    chk("depth", 32'(depth), 32'(exp_q.size()));
    if (e_err) chk("no_strobes", 32'(saw), 32'd0);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
  endtask

  // ---------------- directed then random stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_done",   32'(done),   32'd0);
    chk("rst_err",    32'(err),    32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_depth",  32'(depth),  32'd0);
    chk("rst_strobe", 32'({st_push, st_pop, st_tos}), 32'd0);
    chk("rst_din",    32'(st_din), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(3'd0, 8'h05, 1'b0);
    run_op(3'd0, 8'h03, 1'b0);
    run_op(3'd2, 8'h00, 1'b0);
    chk("peek_val", 32'(result), 32'h03);
    run_op(3'd6, 8'h00, 1'b0);
    chk("sub_val", 32'(result), 32'h02);
    run_op(3'd1, 8'h00, 1'b0);
    chk("pop_depth0", 32'(depth), 32'd0);
    run_op(3'd0, 8'hF0, 1'b0);
    run_op(3'd0, 8'h20, 1'b0);
    run_op(3'd5, 8'h00, 1'b0);
    chk("add_wrap", 32'(result), 32'h10);
    run_op(3'd3, 8'h00, 1'b0);
    run_op(3'd4, 8'h00, 1'b1);
    run_op(3'd0, 8'h11, 1'b1);
    run_op(3'd4, 8'h00, 1'b0);
    while (exp_q.size() > 0) run_op(3'd1, 8'h00, 1'b1);
    run_op(3'd1, 8'h00, 1'b0);
    run_op(3'd2, 8'h00, 1'b0);
    run_op(3'd5, 8'h00, 1'b0);
    while (exp_q.size() < DEPTH) run_op(3'd0, W'($urandom), 1'b0);
    run_op(3'd0, 8'hAA, 1'b0);
    chk("ovf_depth", 32'(depth), 32'd32);
    run_op(3'd3, 8'h00, 1'b0);
    run_op(3'd6, 8'h00, 1'b1);

    // Reset while an ADD sits in CAP_B.
    start = 1'b1; op_i = 3'd5;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy",  32'(busy),  32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("mid_rst_done",   32'(done),   32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    rst = 1'b1;
    exp_q.delete();
    m_result = '0;
    @(negedge clk);
    run_op(3'd0, 8'h7A, 1'b0);
    run_op(3'd2, 8'h00, 1'b0);
    chk("after_rst_peek", 32'(result), 32'h7A);

    for (int i = 0; i < 200; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stack_op_sequencer.md
Name: stack_op_sequencer

Overview:
- Multicycle controller that executes one stack-machine operation per request against the 8-bit LIFO stack datapath. Ops: PUSH, POP, PEEK, DUP, SWAP, ADD, SUB, AND.
- Sequences the stack's push/pop/tos strobes and captures its registered output.
- Tracks depth and rejects operations that would overflow or underflow.
- Sits between the CPU control unit and the stack.

Parameters:
- DEPTH, 32, stack capacity in entries.
- W, 8, data width.
- DW, $clog2(DEPTH+1), depth counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low: asserted when 0.
- start  in  1  request strobe; sampled only in IDLE.
- op  in  3  opcode: 0 PUSH, 1 POP, 2 PEEK, 3 DUP, 4 SWAP, 5 ADD, 6 SUB, 7 AND.
- imm  in  W  PUSH operand; sampled with start.
- busy  out  1  high from the cycle after start acceptance through DONE.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: 1 = op rejected.
- result  out  W  last popped/peeked value or ALU result.
- depth  out  DW  current entry count.
- st_din  out  W  data to stack.
- st_push, st_pop, st_tos  out  1 each  stack strobes; at most one high per cycle.
- st_dout  in  W  stack read data; valid the cycle after st_pop or st_tos.

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE.
  - busy, done, err, st_push, st_pop, st_tos go to 0.
  - result, st_din, depth, opa, opb go to 0.
  - The stack shares the same reset event. Reset mid-op abandons the op with no done pulse.
- States: IDLE, POP_A, POP_B, CAP_B, WR_1, WR_2, DONE.
- Start acceptance:
  - start is accepted in IDLE only. op and imm are latched at acceptance.
  - start in any other state, including DONE, is ignored.
- Legality check at acceptance:
  - Overflow: PUSH or DUP with depth==DEPTH.
  - Underflow: POP, PEEK or DUP with depth<1; SWAP, ADD, SUB or AND with depth<2.
  - Illegal op: go directly to DONE with err=1. No strobes are issued; result and depth are unchanged.
- Legal op: err=0, and the op follows its sequence (cycle 0 = accept cycle):
  - PUSH: WR_1 (st_push, st_din=imm) -> DONE. done at cycle 2.
  - POP: POP_A (st_pop) -> POP_B (result<=st_dout) -> DONE. done at cycle 3.
  - PEEK: POP_A (st_tos) -> POP_B (result<=st_dout) -> DONE. done at cycle 3.
  - DUP: POP_A (st_tos) -> POP_B (opa<=st_dout, result<=st_dout) -> WR_1 (st_push, st_din=opa) -> DONE. done at cycle 4.
  - ADD/SUB/AND:
    - POP_A (st_pop) -> POP_B (opa<=st_dout, st_pop) -> CAP_B (opb<=st_dout) -> WR_1 (st_push of r) -> DONE. done at cycle 5.
    - ADD: r = opb+opa. SUB: r = opb-opa. AND: r = opb&opa. opa is the old top.
    - All arithmetic is W-bit modulo; carry/borrow discarded.
    - result<=r in WR_1.
  - SWAP: POP_A -> POP_B (capture opa, st_pop) -> CAP_B (capture opb) -> WR_1 (push opa) -> WR_2 (push opb) -> DONE. done at cycle 6. New top = old second; result unchanged.
- DONE lasts exactly one cycle with done=1, then returns to IDLE.
- busy:
  - busy=1 in every non-IDLE state; busy=0 in IDLE.
  - Back-to-back ops: start is reasserted in the IDLE cycle after DONE.
- depth:
  - Increments in the cycle st_push is asserted and decrements in the cycle st_pop is asserted (registered, visible next cycle).
  - st_tos leaves depth unchanged.
  - depth never exceeds DEPTH and never wraps below 0.
- Strobes are registered-free Moore decodes of state.
- st_din is driven only during WR_x and is 0 otherwise.
- Net depth change per legal op: PUSH +1, POP -1, PEEK 0, DUP +1, SWAP 0, ALU -1.

Test Plan:
- Reset, then PUSH 0x05 and PUSH 0x03 -> each done at cycle 2 with err=0; depth=2. PEEK -> result=0x03, depth=2.
- From [0x05,0x03]: SUB -> done at cycle 5; result=0x02; depth=1. Follow with POP -> result=0x02, depth=0.
- PUSH 0xF0, PUSH 0x20, ADD -> result=0x10 (wrap). Then DUP -> depth=2. SWAP on [0x10,0x10] -> done at cycle 6, depth=2.
- POP at depth 0 -> done at cycle 1 with err=1; no strobes; result unchanged. Fill to 32 with PUSH -> 33rd PUSH gives err=1, depth stays 32.
- start pulsed while busy and during DONE -> ignored. No extra done; depth consistent with the single accepted op.
- Assert rst=0 during CAP_B of an ADD -> next edge: IDLE, busy=0, depth=0, no done. A subsequent PUSH 0x7A completes normally.
